// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes RX, validates the start bit, samples 8 data bits
// LSB-first at mid-bit, checks the stop bit, and holds the byte behind a rdy/clr_rdy handshake.
module uart_rx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       overrun
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  // The counter holds "cycles remaining minus one", so a full bit period fits in CNT_W bits.
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           r_state, w_next;
  logic             r_rx_meta, r_rx_s;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [3:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_brk;
  logic [7:0]       r_rx_data;
  logic             r_rdy, r_frm_err, r_overrun;

  logic w_expire, w_load_half, w_load_full, w_clr_bits, w_shift, w_good, w_bad;

  assign w_expire = (r_baud_cnt == '0);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next      = r_state;
    w_load_half = 1'b0;
    w_load_full = 1'b0;
    w_clr_bits  = 1'b0;
    w_shift     = 1'b0;
    w_good      = 1'b0;
    w_bad       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // After a low stop bit the line must return high before a new start is accepted.
        if (!r_brk && !r_rx_s) begin
          w_load_half = 1'b1;
          w_next      = S_START;
        end
      end
      S_START: begin
        if (w_expire) begin
          if (r_rx_s) begin
            w_next = S_IDLE;
          end else begin
            w_load_full = 1'b1;
            w_clr_bits  = 1'b1;
            w_next      = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_expire) begin
          w_shift     = 1'b1;
          w_load_full = 1'b1;
          if (r_bit_cnt == 4'd7) w_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_expire) begin
          w_good = r_rx_s;
          w_bad  = ~r_rx_s;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta  <= 1'b1;
      r_rx_s     <= 1'b1;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_brk      <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rdy      <= 1'b0;
      r_frm_err  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_rx_meta <= RX;
      r_rx_s    <= r_rx_meta;

      if (w_load_half)            r_baud_cnt <= HALF_M1;
      else if (w_load_full)       r_baud_cnt <= FULL_M1;
      else if (!w_expire)         r_baud_cnt <= r_baud_cnt - CNT_W'(1);

      if (w_clr_bits)             r_bit_cnt <= '0;
      else if (w_shift)           r_bit_cnt <= r_bit_cnt + 4'd1;

      if (w_shift) r_shift <= {r_rx_s, r_shift[7:1]};

      r_frm_err <= w_bad;
      r_overrun <= w_good & r_rdy & ~clr_rdy;

      // A completing byte wins over a simultaneous clear.
      if (w_good) begin
        r_rx_data <= r_shift;
        r_rdy     <= 1'b1;
      end else if (clr_rdy) begin
        r_rdy     <= 1'b0;
      end

      if (w_bad)                              r_brk <= 1'b1;
      else if (r_state == S_IDLE && r_rx_s)   r_brk <= 1'b0;
    end
  end

  assign rx_data = r_rx_data;
  assign rdy     = r_rdy;
  assign frm_err = r_frm_err;
  assign overrun = r_overrun;

endmodule
